// File: rtl/dmem_ctrl.sv
// dmem_ctrl: two-port data memory controller, IDLE/ACCESS/RESP FSM, lane steering and load extension (DMEM_CTRL_RR_EN selects round-robin arbitration)
module dmem_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [1:0]  p0_size,
    input  logic        p0_unsigned,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [1:0]  p1_size,
    input  logic        p1_unsigned,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_wmask,
    input  logic [31:0] mem_rd
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state;
    logic        id_q, we_q, uns_q, rv_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        idle, acc, g0, g1, illegal, rv;
    logic [31:0] lane, ext;

    assign idle = state == IDLE && !reset;
    assign acc  = state == ACCESS && !reset;
`ifdef DMEM_CTRL_RR_EN
    logic last_q;
    assign g0 = idle && p0_req && (!p1_req || last_q);
    assign g1 = idle && p1_req && (!p0_req || !last_q);
    // remember which port won most recently so ties alternate
    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b1;
        else if (g0 || g1) last_q <= g1;
    end
`else
    assign g0 = idle && p0_req;
    assign g1 = idle && p1_req && !p0_req;
`endif
    assign p0_gnt = g0;
    assign p1_gnt = g1;

    assign illegal = size_q == 2'b11 || (size_q == 2'b01 && addr_q[0]) ||
                     (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    assign mem_we    = acc && we_q && !illegal;
    assign mem_a     = acc ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wmask = !mem_we ? 32'd0 :
                       size_q == 2'b00 ? 32'h0000_00FF << {addr_q[1:0], 3'b000} :
                       size_q == 2'b01 ? 32'h0000_FFFF << {addr_q[1], 4'b0000} : 32'hFFFF_FFFF;
    assign mem_wd    = !mem_we ? 32'd0 :
                       size_q == 2'b00 ? {4{wdata_q[7:0]}} :
                       size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;

    // legal halves/words are aligned, so a byte-granular shift selects every lane
    assign lane = mem_rd >> {addr_q[1:0], 3'b000};
    assign ext  = size_q == 2'b00 ? {{24{lane[7] & ~uns_q}}, lane[7:0]} :
                  size_q == 2'b01 ? {{16{lane[15] & ~uns_q}}, lane[15:0]} : lane;

    assign rv        = rv_q && !reset;
    assign p0_rvalid = rv && !id_q;
    assign p1_rvalid = rv && id_q;
    assign p0_err    = p0_rvalid && err_q;
    assign p1_err    = p1_rvalid && err_q;
    assign p0_rdata  = p0_rvalid ? rdata_q : 32'd0;
    assign p1_rdata  = p1_rvalid ? rdata_q : 32'd0;

    // request latch, state sequencing and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            case (state)
                IDLE: if (g0 || g1) begin
                    state   <= ACCESS;
                    id_q    <= g1;
                    we_q    <= g1 ? p1_we : p0_we;
                    addr_q  <= g1 ? p1_addr : p0_addr;
                    size_q  <= g1 ? p1_size : p0_size;
                    uns_q   <= g1 ? p1_unsigned : p0_unsigned;
                    wdata_q <= g1 ? p1_wdata : p0_wdata;
                end
                ACCESS: begin
                    state   <= RESP;
                    rv_q    <= 1'b1;
                    err_q   <= illegal;
                    rdata_q <= (we_q || illegal) ? 32'd0 : ext;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized and directed checks of dmem_ctrl against a byte-array memory model
module tb_dmem_ctrl;
    logic        clk = 1'b0, reset;
    logic        p0_req, p0_we, p0_unsigned, p0_gnt, p0_rvalid, p0_err;
    logic [1:0]  p0_size;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_unsigned, p1_gnt, p1_rvalid, p1_err;
    logic [1:0]  p1_size;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_wmask, mem_rd;
    logic [31:0] tb_mem [64];
    logic [7:0]  ref_mem [256];
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_size(p0_size),
        .p0_unsigned(p0_unsigned), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_size(p1_size),
        .p1_unsigned(p1_unsigned), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_wmask(mem_wmask),
        .mem_rd(mem_rd)
    );

    // memory environment: asynchronous read, masked write on the clock edge
    assign mem_rd = tb_mem[mem_a[7:2]];
    always @(posedge clk)
        if (mem_we) tb_mem[mem_a[7:2]] <= (tb_mem[mem_a[7:2]] & ~mem_wmask) | (mem_wd & mem_wmask);

    task automatic drive(input int p, input logic req, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        if (p == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_size = size; p0_unsigned = uns; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_size = size; p1_unsigned = uns; p1_wdata = wdata;
        end
    endtask

    task automatic access(input int p, input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output logic [31:0] got_rdata, output logic got_err);
        int n, off, cnt;
        logic ill, g;
        logic [31:0] e_mask, e_wd, e_rd;
        n = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
        off = int'(addr[1:0]);
        ill = size == 2'd3 || (off % n) != 0;
        e_mask = 0; e_wd = 0; e_rd = 0;
        if (!ill && we)
            for (int i = 0; i < 4; i++) begin
                e_wd[8*i +: 8] = wdata[8*(i % n) +: 8];
                if (i >= off && i < off + n) e_mask[8*i +: 8] = 8'hFF;
            end
        if (!ill && !we) begin
            for (int i = 0; i < n; i++) e_rd[8*i +: 8] = ref_mem[int'(addr[7:0]) + i];
            if (n < 4 && !uns && e_rd[8*n-1])
                for (int i = n; i < 4; i++) e_rd[8*i +: 8] = 8'hFF;
        end
        @(negedge clk);
        drive(p, 1'b1, we, addr, size, uns, wdata);
        #1;
        cnt = 0;
        g = p == 0 ? p0_gnt : p1_gnt;
        while (!g && cnt < 20) begin
            @(negedge clk); #1;
            g = p == 0 ? p0_gnt : p1_gnt;
            cnt++;
        end
        n_cmp++;
        if (g !== 1'b1) begin
            n_err++; $display("FAIL grant_timeout port=%0d got=%b want=1", p, g);
        end
        @(negedge clk);
        drive(p, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        n_cmp++;
        if (mem_we !== (we && !ill)) begin
            n_err++; $display("FAIL mem_we addr=%h got=%b want=%b", addr, mem_we, we && !ill);
        end
        n_cmp++;
        if (mem_wmask !== e_mask) begin
            n_err++; $display("FAIL mem_wmask addr=%h got=%h want=%h", addr, mem_wmask, e_mask);
        end
        n_cmp++;
        if (mem_wd !== e_wd) begin
            n_err++; $display("FAIL mem_wd addr=%h got=%h want=%h", addr, mem_wd, e_wd);
        end
        if (!ill) begin
            n_cmp++;
            if (mem_a !== {addr[31:2], 2'b00}) begin
                n_err++; $display("FAIL mem_a got=%h want=%h", mem_a, {addr[31:2], 2'b00});
            end
        end
        if (we && !ill)
            for (int i = 0; i < n; i++) ref_mem[int'(addr[7:0]) + i] = wdata[8*i +: 8];
        @(negedge clk);
        got_rdata = p == 0 ? p0_rdata : p1_rdata;
        got_err = p == 0 ? p0_err : p1_err;
        n_cmp++;
        if ((p == 0 ? p0_rvalid : p1_rvalid) !== 1'b1 || (p == 0 ? p1_rvalid : p0_rvalid) !== 1'b0) begin
            n_err++; $display("FAIL rvalid port=%0d got=%b%b want=one-hot", p, p1_rvalid, p0_rvalid);
        end
        n_cmp++;
        if (got_rdata !== e_rd) begin
            n_err++; $display("FAIL rdata port=%0d addr=%h got=%h want=%h", p, addr, got_rdata, e_rd);
        end
        n_cmp++;
        if (got_err !== ill) begin
            n_err++; $display("FAIL err port=%0d addr=%h size=%0d got=%b want=%b", p, addr, size, got_err, ill);
        end
        @(negedge clk);
        n_cmp++;
        if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || p0_rdata !== 32'd0 || p1_rdata !== 32'd0) begin
            n_err++; $display("FAIL idle_resp got=%b%b %h %h want=0", p1_rvalid, p0_rvalid, p1_rdata, p0_rdata);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 32'h10, 2'd2, 1'b0, 32'hFFFF_FFFF);
        drive(1, 1'b1, 1'b1, 32'h14, 2'd2, 1'b0, 32'hFFFF_FFFF);
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we} !== 7'd0 ||
                {p0_rdata, p1_rdata, mem_a, mem_wd, mem_wmask} !== 160'd0) begin
                n_err++; $display("FAIL reset_outputs got gnt=%b%b rv=%b%b we=%b a=%h want=0",
                                  p1_gnt, p0_gnt, p1_rvalid, p0_rvalid, mem_we, mem_a);
            end
        end
        drive(0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        reset = 1'b0;
    endtask

    task automatic test_word;
        logic [31:0] d; logic e;
        access(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, d, e);
        access(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'd0, d, e);
        n_cmp++;
        if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin
            n_err++; $display("FAIL word_load got=%h/%b want=deadbeef/0", d, e);
        end
    endtask

    task automatic test_byte;
        logic [31:0] d; logic e;
        access(0, 1'b1, 32'h13, 2'd0, 1'b0, 32'h0000_0080, d, e);
        access(0, 1'b0, 32'h13, 2'd0, 1'b0, 32'd0, d, e);
        n_cmp++;
        if (d !== 32'hFFFF_FF80) begin
            n_err++; $display("FAIL byte_signed got=%h want=ffffff80", d);
        end
        access(0, 1'b0, 32'h13, 2'd0, 1'b1, 32'd0, d, e);
        n_cmp++;
        if (d !== 32'h0000_0080) begin
            n_err++; $display("FAIL byte_unsigned got=%h want=00000080", d);
        end
    endtask

    task automatic test_illegal;
        logic [31:0] d; logic e;
        access(1, 1'b0, 32'h11, 2'd1, 1'b0, 32'd0, d, e);
        n_cmp++;
        if (d !== 32'd0 || e !== 1'b1) begin
            n_err++; $display("FAIL misaligned_half got=%h/%b want=0/1", d, e);
        end
        access(1, 1'b1, 32'h14, 2'd3, 1'b0, 32'hCAFE_F00D, d, e);
        n_cmp++;
        if (d !== 32'd0 || e !== 1'b1) begin
            n_err++; $display("FAIL size11_store got=%h/%b want=0/1", d, e);
        end
        access(0, 1'b1, 32'h16, 2'd2, 1'b0, 32'h1111_2222, d, e);
    endtask

    task automatic test_random;
        logic [31:0] d; logic e;
        for (int k = 0; k < 60; k++)
            access(int'($urandom_range(1, 0)), 1'($urandom), 32'($urandom_range(255, 0)),
                   2'($urandom), 1'($urandom), $urandom, d, e);
    endtask

    task automatic test_abort;
        logic [31:0] old;
        int cnt;
        old = tb_mem[8];
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 2'd2, 1'b0, 32'h1234_5678);
        #1;
        cnt = 0;
        while (!p0_gnt && cnt < 20) begin @(negedge clk); #1; cnt++; end
        n_cmp++;
        if (p0_gnt !== 1'b1) begin
            n_err++; $display("FAIL abort_grant got=%b want=1", p0_gnt);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_err++; $display("FAIL abort_mem_we got=%b want=0", mem_we);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
            n_err++; $display("FAIL abort_rvalid got=%b%b want=00", p1_rvalid, p0_rvalid);
        end
        drive(1, 1'b1, 1'b0, 32'h20, 2'd2, 1'b0, 32'd0);
        #1;
        n_cmp++;
        if (p1_gnt !== 1'b1) begin
            n_err++; $display("FAIL abort_idle_gnt got=%b want=1", p1_gnt);
        end
        drive(1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
                n_err++; $display("FAIL abort_late_rvalid got=%b%b want=00", p1_rvalid, p0_rvalid);
            end
        end
        n_cmp++;
        if (tb_mem[8] !== old) begin
            n_err++; $display("FAIL abort_memory got=%h want=%h", tb_mem[8], old);
        end
    endtask

    task automatic test_back_to_back;
        logic rr, e0, e1;
`ifdef DMEM_CTRL_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h0, 2'd2, 1'b0, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h4, 2'd2, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            e1 = c % 3 == 0 && rr && (c / 3) % 2 == 1;
            e0 = c % 3 == 0 && !e1;
            n_cmp++;
            if (p0_gnt !== e0 || p1_gnt !== e1) begin
                n_err++; $display("FAIL arb cycle=%0d got=%b%b want=%b%b", c, p1_gnt, p0_gnt, e1, e0);
            end
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            tb_mem[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = tb_mem[i][8*b +: 8];
        end
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        test_reset;
        test_word;
        test_byte;
        test_illegal;
        test_random;
        test_abort;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
